// File: rtl/simon_ti3_dec_serial.sv
// simon_ti3_dec_serial: bit-serial 3-share threshold-implementation Simon decryption core.
// Defining SIMON_TI_REMASK_EN adds the rnd port and refreshes the new share bits every RUN cycle.
module simon_ti3_dec_serial #(
  parameter int N = 32,
  parameter int ROUNDS = 42
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [2*N-1:0] ct_a,
  input  logic [2*N-1:0] ct_b,
  input  logic [2*N-1:0] ct_c,
  output logic key_req,
  input  logic key_a,
  input  logic key_b,
  input  logic key_c,
`ifdef SIMON_TI_REMASK_EN
  input  logic [1:0] rnd,
`endif
  output logic out_valid,
  input  logic out_ready,
  output logic [2*N-1:0] pt_a,
  output logic [2*N-1:0] pt_b,
  output logic [2*N-1:0] pt_c
);
  localparam int BW = $clog2(N);
  localparam int RW = $clog2(ROUNDS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] l [3], r [3], rot1 [3], rot2 [3], rot8 [3], shf [3];
  logic [2*N-1:0] ct [3];
  logic [2:0] key, fbit, msk;
  logic [BW-1:0] bcnt;
  logic [RW-1:0] rcnt;
  logic last_bit, last_round;
  assign ct = '{ct_a, ct_b, ct_c};
  assign key = {key_c, key_b, key_a};
`ifdef SIMON_TI_REMASK_EN
  assign msk = {rnd[0] ^ rnd[1], rnd[1], rnd[0]};
`else
  assign msk = '0;
`endif
  assign last_bit = bcnt == BW'(N - 1);
  assign last_round = rcnt == RW'(ROUNDS - 1);
  assign in_ready = state == IDLE;
  assign key_req = state == RUN;
  assign out_valid = state == DONE;
  assign pt_a = {l[0], r[0]};
  assign pt_b = {l[1], r[1]};
  assign pt_c = {l[2], r[2]};
  // share s pairs with share s+1 (a,b), (b,c), (c,a) so no f_s sees all three shares
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      rot1[s] = {r[s][N-2:0], r[s][N-1]};
      rot2[s] = {r[s][N-3:0], r[s][N-1:N-2]};
      rot8[s] = {r[s][N-9:0], r[s][N-1:N-8]};
    end
    for (int s = 0; s < 3; s++) begin
      fbit[s] = rot2[s][bcnt] ^ (rot1[s][bcnt] & rot8[s][bcnt])
              ^ (rot1[s][bcnt] & rot8[(s + 1) % 3][bcnt]) ^ (rot1[(s + 1) % 3][bcnt] & rot8[s][bcnt]);
      shf[s] = {l[s][0] ^ key[s] ^ fbit[s] ^ msk[s], l[s][N-1:1]};
    end
  end
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE)
            : state == RUN ? (last_bit && last_round ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcnt <= '0;
      rcnt <= '0;
      for (int s = 0; s < 3; s++) begin
        l[s] <= '0;
        r[s] <= '0;
      end
    end else begin
      state <= state_n;
      bcnt <= state == RUN && !last_bit ? bcnt + BW'(1) : '0;
      rcnt <= state == RUN ? rcnt + RW'(last_bit) : '0;
      for (int s = 0; s < 3; s++) begin
        if (state == IDLE && in_valid) begin
          l[s] <= ct[s][2*N-1:N];
          r[s] <= ct[s][N-1:0];
        end else if (state == RUN) begin
          l[s] <= last_bit ? r[s] : shf[s];
          if (last_bit) r[s] <= shf[s];
        end
      end
    end
  end
endmodule

// File: tb/tb_simon_ti3_dec_serial.sv
// tb_simon_ti3_dec_serial: directed bench for the 3-share serial Simon64/96 decryption core.
module tb_simon_ti3_dec_serial;
  localparam logic [63:0] CT = 64'h5ca2e27f111a8fc8;
  localparam logic [63:0] PT = 64'h6f7220676e696c63;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic key_a = 0, key_b = 0, key_c = 0;
  logic in_ready, key_req, out_valid;
  logic [63:0] ct_a = 0, ct_b = 0, ct_c = 0, pt_a, pt_b, pt_c;
`ifdef SIMON_TI_REMASK_EN
  logic [1:0] rnd = 0;
`endif
  int checks = 0, errors = 0, kidx = 0, lat = 0, kreq = 0;
  bit ksplit = 0;
  logic [31:0] rk [42];
  logic [63:0] z2 = 64'h7369f885192c0ef5;

  always #5 clk = ~clk;

  simon_ti3_dec_serial dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ct_a(ct_a), .ct_b(ct_b), .ct_c(ct_c), .key_req(key_req),
    .key_a(key_a), .key_b(key_b), .key_c(key_c),
`ifdef SIMON_TI_REMASK_EN
    .rnd(rnd),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .pt_a(pt_a), .pt_b(pt_b), .pt_c(pt_c)
  );

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drives bit kidx%32 of round key rk[41-kidx/32], optionally split into random shares
  task automatic set_key();
    logic kbit, kb, kc;
    kbit = kidx < 1344 ? rk[41 - kidx / 32][kidx % 32] : 1'b0;
    kb = ksplit ? 1'($urandom) : 1'b0;
    kc = ksplit ? 1'($urandom) : 1'b0;
    key_a = kbit ^ kb ^ kc;
    key_b = kb;
    key_c = kc;
`ifdef SIMON_TI_REMASK_EN
    rnd = 2'($urandom);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    kidx++;
    set_key();
  endtask

  task automatic start(input logic [63:0] sb, input logic [63:0] sc, input bit ks);
    ksplit = ks;
    ct_b = sb;
    ct_c = sc;
    ct_a = CT ^ sb ^ sc;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    kidx = 0;
    set_key();
  endtask

  task automatic wait_done();
    lat = 1;
    kreq = 0;
    while (!out_valid && lat < 2000) begin
      if (key_req) kreq++;
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("release", 200'({in_ready, out_valid, key_req}), 200'(3'b100));
  endtask

  initial begin
    logic [31:0] t;
    logic [191:0] hold;
    rk[0] = 32'h03020100;
    rk[1] = 32'h0b0a0908;
    rk[2] = 32'h13121110;
    for (int i = 3; i < 42; i++) begin
      t = {rk[i-1][2:0], rk[i-1][31:3]};
      t = t ^ {t[0], t[31:1]};
      rk[i] = ~rk[i-3] ^ t ^ {31'd0, z2[i-3]} ^ 32'd3;
    end
    repeat (3) @(negedge clk);
    chk("reset_ctl", 200'({in_ready, out_valid, key_req}), 200'(3'b100));
    chk("reset_pt", 200'({pt_a, pt_b, pt_c}), 200'(0));
    reset = 0;
    @(negedge clk);
    chk("idle_ctl", 200'({in_ready, out_valid, key_req}), 200'(3'b100));

    start(64'd0, 64'd0, 1'b0);
    wait_done();
    chk("latency", 200'(lat), 200'(1345));
    chk("key_req_cycles", 200'(kreq), 200'(1344));
    chk("done_ctl", 200'({in_ready, out_valid, key_req}), 200'(3'b010));
    chk("unshared_recomb", 200'(pt_a ^ pt_b ^ pt_c), 200'(PT));
`ifdef SIMON_TI_REMASK_EN
    chk("remask_pt_b_nonzero", 200'(pt_b != 64'd0), 200'(1));
`else
    chk("unshared_pt_a", 200'(pt_a), 200'(PT));
    chk("unshared_pt_bc", 200'({pt_b, pt_c}), 200'(0));
`endif

    hold = {pt_a, pt_b, pt_c};
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("backpressure_hold", 200'({out_valid, in_ready, key_req, pt_a, pt_b, pt_c}), 200'({3'b100, hold}));
      in_valid = (k % 7 == 3);
      ct_a = {$urandom, $urandom};
    end
    in_valid = 0;
    drain();

    for (int n = 0; n < 8; n++) begin
      start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      wait_done();
      chk("shared_latency", 200'(lat), 200'(1345));
      chk("shared_recomb", 200'(pt_a ^ pt_b ^ pt_c), 200'(PT));
      drain();
    end

    start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (647) tick();
    reset = 1;
    @(negedge clk);
    chk("midrun_reset_ctl", 200'({in_ready, out_valid, key_req}), 200'(3'b100));
    chk("midrun_reset_pt", 200'({pt_a, pt_b, pt_c}), 200'(0));
    reset = 0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", 200'({in_ready, out_valid, key_req}), 200'(3'b100));

    start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    wait_done();
    chk("after_reset_latency", 200'(lat), 200'(1345));
    chk("after_reset_recomb", 200'(pt_a ^ pt_b ^ pt_c), 200'(PT));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
